mi32_reg_responder: RTL and testbench

MI32_REG_RESPONDER -- requirements
Module: mi32_reg_responder

---
 rtl/mi32_resp_pkg.sv | 31 +++
 rtl/mi32_resp_rdpipe.sv | 44 ++++
 rtl/mi32_reg_responder.sv | 115 +++++++++++
 tb/tb_mi32_reg_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mi32_resp_pkg.sv
// Shared constants for the MI32 register responder: register map, ID default,
// out-of-window read value, and a byte-enable merge helper.
// No logic or ports; imported by mi32_reg_responder and its read pipeline.
package mi32_resp_pkg;

   // Register word indices inside the 16-word window
   localparam logic [3:0] IDX_ID        = 4'd0;
   localparam logic [3:0] IDX_SCR_FIRST = 4'd1;
   localparam logic [3:0] IDX_SCR_LAST  = 4'd13;
   localparam logic [3:0] IDX_WR_CNT    = 4'd14;
   localparam logic [3:0] IDX_RD_CNT    = 4'd15;

   localparam int NUM_SCR = int'(IDX_SCR_LAST) - int'(IDX_SCR_FIRST) + 1;

   localparam logic [31:0] WINDOW_BYTES = 32'd64;
   localparam logic [31:0] ID_DEFAULT   = 32'h4D49_3332;
   localparam logic [31:0] OOW_RDATA    = 32'hDEAD_BEEF;

   // Replace only the bytes of old_v whose enable bit is set
   function automatic logic [31:0] apply_be(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = old_v;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/mi32_resp_rdpipe.sv
// Read-data delay line: valid + 32-bit data shifted through DEPTH registers.
// Latency DEPTH cycles; no backpressure, accepts one entry every cycle.
// Ports: clk, rst_n (sync, active-low) | in_vld/in_dat -> out_vld/out_dat.
module mi32_resp_rdpipe #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_vld,
   input  logic [31:0] in_dat,
   output logic        out_vld,
   output logic [31:0] out_dat
);

   logic [DEPTH-1:0] vld_q, vld_d;
   logic [31:0]      dat_q [DEPTH];
   logic [31:0]      dat_d [DEPTH];

   always_comb begin
      vld_d    = '0;
      vld_d[0] = in_vld;
      for (int i = 0; i < DEPTH; i++) dat_d[i] = '0;
      // Data is zeroed for empty slots so the output is 0 whenever invalid
      dat_d[0] = in_vld ? in_dat : '0;
      for (int i = 1; i < DEPTH; i++) begin
         vld_d[i] = vld_q[i-1];
         dat_d[i] = dat_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
      end else begin
         vld_q <= vld_d;
         for (int i = 0; i < DEPTH; i++) dat_q[i] <= dat_d[i];
      end
   end

   assign out_vld = vld_q[DEPTH-1];
   assign out_dat = dat_q[DEPTH-1];

endmodule

// File: rtl/mi32_reg_responder.sv
// MI32 slave with a 16-word register window: ID, 13 scratch, write/read counters.
// Reads return READ_LATENCY cycles after acceptance; writes take effect next cycle.
// No backpressure: ARDY follows RD|WR out of reset, every request accepted at once.
// Ports: CLK, RESET (sync, active-low) | ADDR, DWR, BE, RD, WR in | ARDY, DRDY, DRD out.
module mi32_reg_responder
   import mi32_resp_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
   parameter int          READ_LATENCY = 2,
   parameter logic [31:0] ID_VALUE     = ID_DEFAULT
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] ADDR,
   input  logic [31:0] DWR,
   input  logic [3:0]  BE,
   input  logic        RD,
   input  logic        WR,
   output logic        ARDY,
   output logic        DRDY,
   output logic [31:0] DRD
);

   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("mi32_reg_responder: READ_LATENCY must be within 1..4");
   end

   logic        wr_acc, rd_acc;
   logic [31:0] offset;
   logic        hit;
   logic [3:0]  idx;
   logic        unused_addr_lsb;
   logic [31:0] rd_dat;

   logic [31:0] scratch_q [NUM_SCR];
   logic [31:0] scratch_d [NUM_SCR];
   logic [31:0] wr_cnt_q, wr_cnt_d;
   logic [31:0] rd_cnt_q, rd_cnt_d;

   logic        pipe_vld;
   logic [31:0] pipe_dat;

   // RD together with WR is treated as a write only
   assign wr_acc = RESET & WR;
   assign rd_acc = RESET & RD & ~WR;
   assign ARDY   = RESET & (RD | WR);

   // Unsigned subtraction wraps, so addresses below the base fall outside too
   assign offset          = ADDR - ADDR_BASE;
   assign hit             = (offset < WINDOW_BYTES);
   assign idx             = offset[5:2];
   assign unused_addr_lsb = ^offset[1:0];

   always_comb begin
      for (int i = 0; i < NUM_SCR; i++) scratch_d[i] = scratch_q[i];
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      if (wr_acc) begin
         wr_cnt_d = wr_cnt_q + 32'd1;
         for (int i = 0; i < NUM_SCR; i++) begin
            if (hit && idx == IDX_SCR_FIRST + 4'(i)) begin
               scratch_d[i] = apply_be(scratch_q[i], DWR, BE);
            end
         end
      end
      if (rd_acc) rd_cnt_d = rd_cnt_q + 32'd1;
   end

   // Read data comes from current state, i.e. before this cycle's updates
   always_comb begin
      rd_dat = '0;
      if (!hit) begin
         rd_dat = OOW_RDATA;
      end else begin
         case (idx)
            IDX_ID:     rd_dat = ID_VALUE;
            IDX_WR_CNT: rd_dat = wr_cnt_q;
            IDX_RD_CNT: rd_dat = rd_cnt_q;
            default: begin
               for (int i = 0; i < NUM_SCR; i++) begin
                  if (idx == IDX_SCR_FIRST + 4'(i)) rd_dat = scratch_q[i];
               end
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         for (int i = 0; i < NUM_SCR; i++) scratch_q[i] <= '0;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         for (int i = 0; i < NUM_SCR; i++) scratch_q[i] <= scratch_d[i];
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
      end
   end

   mi32_resp_rdpipe #(
      .DEPTH (READ_LATENCY)
   ) u_rdpipe (
      .clk     (CLK),
      .rst_n   (RESET),
      .in_vld  (rd_acc),
      .in_dat  (rd_dat),
      .out_vld (pipe_vld),
      .out_dat (pipe_dat)
   );

   // Gated by RESET so outputs are quiet throughout the reset cycle itself
   assign DRDY = RESET & pipe_vld;
   assign DRD  = DRDY ? pipe_dat : '0;

endmodule

// File: tb/tb_mi32_reg_responder.sv
module tb_mi32_reg_responder;

   localparam logic [31:0] BASE = 32'h4000_0100;
   localparam int          LAT  = 2;
   localparam logic [31:0] ID   = 32'h4D49_3332;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic [31:0] ADDR = '0;
   logic [31:0] DWR = '0;
   logic [3:0]  BE = '0;
   logic        RD = 1'b0;
   logic        WR = 1'b0;
   logic        ARDY, DRDY;
   logic [31:0] DRD;

   mi32_reg_responder #(
      .ADDR_BASE    (BASE),
      .READ_LATENCY (LAT),
      .ID_VALUE     (ID)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .ADDR  (ADDR),
      .DWR   (DWR),
      .BE    (BE),
      .RD    (RD),
      .WR    (WR),
      .ARDY  (ARDY),
      .DRDY  (DRDY),
      .DRD   (DRD)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard of outstanding reads
   typedef struct {
      int          due;
      logic [31:0] dat;
   } sb_t;
   sb_t sb[$];

   always @(negedge CLK) begin
      if (DRDY === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_drdy", 32'(DRDY), 32'd0);
         end else begin
            sb_t e;
            e = sb.pop_front();
            check("drd", DRD, e.dat);
            check("drdy_timing", 32'(cyc), 32'(e.due));
         end
      end else begin
         check("drd_idle_zero", DRD, 32'd0);
      end
   end

   // One request per cycle; ARDY checked combinationally in the same cycle
   task automatic drive(input logic rd, input logic wr, input logic [31:0] off,
                        input logic [31:0] dwr, input logic [3:0] be,
                        input logic push, input logic [31:0] exp);
      sb_t e;
      @(posedge CLK);
      #1;
      RD = rd; WR = wr; ADDR = BASE + off; DWR = dwr; BE = be;
      #1;
      check("ardy", 32'(ARDY), 32'(RESET & (rd | wr)));
      if (push) begin
         e.due = cyc + LAT;
         e.dat = exp;
         sb.push_back(e);
      end
   endtask

   task automatic rd_exp(input logic [31:0] off, input logic [31:0] exp);
      drive(1'b1, 1'b0, off, 32'd0, 4'h0, 1'b1, exp);
   endtask

   task automatic wr_op(input logic [31:0] off, input logic [31:0] dwr, input logic [3:0] be);
      drive(1'b0, 1'b1, off, dwr, be, 1'b0, 32'd0);
   endtask

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] off;
      logic [31:0] dwr;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[$];

   function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] off,
                               input logic [31:0] dwr, input logic [3:0] be,
                               input logic [31:0] exp);
      vec_t v;
      v.rd = rd; v.wr = wr; v.off = off; v.dwr = dwr; v.be = be; v.exp = exp;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Expected results; reads carry the value the DUT must return
      vecs.push_back(mk(1, 0, 32'h00, 0, 4'h0, ID));             // ID
      vecs.push_back(mk(1, 0, 32'h3C, 0, 4'h0, 32'd1));          // RD_CNT before increment
      vecs.push_back(mk(0, 1, 32'h0C, 32'h1122_3344, 4'b0101, 0)); // during first DRDY
      vecs.push_back(mk(1, 0, 32'h0C, 0, 4'h0, 32'h0022_0044));
      for (int k = 1; k <= 8; k++) vecs.push_back(mk(0, 1, 32'(4*k), 32'(k), 4'hF, 0));
      for (int k = 1; k <= 8; k++) vecs.push_back(mk(1, 0, 32'(4*k), 0, 4'h0, 32'(k)));
      vecs.push_back(mk(1, 0, 32'h40, 0, 4'h0, 32'hDEAD_BEEF));   // just past window
      vecs.push_back(mk(0, 1, 32'h00, 32'd0, 4'hF, 0));           // write to ID ignored
      vecs.push_back(mk(1, 0, 32'h00, 0, 4'h0, ID));
      vecs.push_back(mk(1, 0, 32'h38, 0, 4'h0, 32'd10));          // WR_CNT
      vecs.push_back(mk(1, 1, 32'h08, 32'hA5A5_A5A5, 4'hF, 0));   // RD+WR = write only
      vecs.push_back(mk(1, 0, 32'h08, 0, 4'h0, 32'hA5A5_A5A5));
      vecs.push_back(mk(1, 0, 32'h3C, 0, 4'h0, 32'd15));          // RD_CNT
      vecs.push_back(mk(0, 1, 32'h38, 32'hFFFF_FFFF, 4'hF, 0));   // write to WR_CNT ignored
      vecs.push_back(mk(1, 0, 32'h38, 0, 4'h0, 32'd12));
      vecs.push_back(mk(0, 1, 32'h14, 32'hFFFF_FFFF, 4'h0, 0));   // BE=0 write
      vecs.push_back(mk(1, 0, 32'h14, 0, 4'h0, 32'd5));
      vecs.push_back(mk(0, 0, 32'h00, 0, 4'h0, 0));               // idle
      vecs.push_back(mk(1, 0, 32'h13, 0, 4'h0, 32'd4));           // ADDR[1:0] ignored
      vecs.push_back(mk(1, 0, 32'hFFFF_FFFC, 0, 4'h0, 32'hDEAD_BEEF)); // below base

      // Reset with a request presented: nothing accepted, outputs quiet
      RESET = 1'b0; RD = 1'b1; ADDR = BASE;
      repeat (3) begin
         @(negedge CLK);
         check("reset_ardy", 32'(ARDY), 32'd0);
         check("reset_drdy", 32'(DRDY), 32'd0);
      end
      @(posedge CLK);
      #1;
      RESET = 1'b1; RD = 1'b0;
      #1;
      check("post_reset_ardy", 32'(ARDY), 32'd0);
      @(negedge CLK);
      check("post_reset_drdy", 32'(DRDY), 32'd0);

      foreach (vecs[i]) begin
         drive(vecs[i].rd, vecs[i].wr, vecs[i].off, vecs[i].dwr, vecs[i].be,
               vecs[i].rd & ~vecs[i].wr, vecs[i].exp);
      end
      drive(0, 0, 0, 0, 4'h0, 1'b0, 32'd0);

      // Reads in flight are dropped by a one-cycle reset
      drive(1, 0, 32'h04, 0, 4'h0, 1'b0, 32'd0);
      drive(1, 0, 32'h08, 0, 4'h0, 1'b0, 32'd0);
      @(posedge CLK);
      #1;
      RESET = 1'b0; RD = 1'b0;
      #1;
      check("midreset_ardy", 32'(ARDY), 32'd0);
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      repeat (5) drive(0, 0, 0, 0, 4'h0, 1'b0, 32'd0);
      rd_exp(32'h3C, 32'd0);          // RD_CNT cleared
      rd_exp(32'h38, 32'd0);          // WR_CNT cleared
      rd_exp(32'h14, 32'd0);          // scratch cleared
      wr_op(32'h00, 32'd0, 4'hF);
      rd_exp(32'h00, ID);
      rd_exp(32'h38, 32'd1);
      drive(0, 0, 0, 0, 4'h0, 1'b0, 32'd0);

      // Drain, bounded
      for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge CLK);
      repeat (3) @(posedge CLK);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
